// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and imem fetch sequencer with buffered redirects; PC_ALIGN_CHECK_EN adds a sticky misalign check.
module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] current_address,
  input  logic [ADDR_WIDTH-1:0] next_address,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  halt,
  output logic                  imem_req,
  input  logic                  imem_ack,
  output logic                  halted,
  output logic                  misalign_err
);
  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, sel_pc, redir_tgt;
  logic                  pend_v_q, pend_v_d, halt_pend_q, halt_pend_d;
  logic                  in_fetch, ack, redir;
  always_comb begin
    in_fetch    = state_q == FETCH;
    ack         = in_fetch & imem_ack;
    redir       = in_fetch & (jump | branch_taken);
    redir_tgt   = jump ? jump_target : branch_target;
    sel_pc      = (jump | branch_taken) ? redir_tgt : pend_v_q ? pend_tgt_q : next_address;
    pc_d        = ack ? sel_pc : pc_q;
    pend_v_d    = ack ? 1'b0 : pend_v_q | redir;
    pend_tgt_d  = (redir && !ack) ? redir_tgt : pend_tgt_q;
    halt_pend_d = ack ? 1'b0 : halt_pend_q | (in_fetch & halt);
    state_d     = state_q == BOOT ? FETCH :
                  (ack && (halt_pend_q || halt)) ? HALTED : state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_tgt_q  <= pend_tgt_d;
      halt_pend_q <= halt_pend_d;
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  logic err_q, err_d;
  // only redirect targets are checked; sequential next_address is trusted
  always_comb err_d = err_q | (ack & (jump | branch_taken | pend_v_q) & (sel_pc[1:0] != 2'b00));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif
  assign current_address = pc_q;
  assign imem_req        = in_fetch;
  assign halted          = state_q == HALTED;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed-vector bench for pc_fetch_ctrl with a +4 pc_adder model.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] current_address, next_address, branch_target = '0, jump_target = '0;
  logic        branch_taken = 1'b0, jump = 1'b0, halt = 1'b0, imem_ack = 1'b0;
  logic        imem_req, halted, misalign_err;
  int          n_vec = 0, n_err = 0;
  logic        exp_err;
  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .current_address(current_address), .next_address(next_address),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .halt(halt), .imem_req(imem_req), .imem_ack(imem_ack),
    .halted(halted), .misalign_err(misalign_err)
  );
  assign next_address = current_address + 16'd4;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
`ifdef PC_ALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    imem_ack = 1'b1;
    #12;
    check("rst_pc", current_address, 16'h0000);
    check("rst_req", imem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_err", misalign_err, 0);
    @(negedge clk) reset = 1'b0;
    #1 check("boot_req", imem_req, 0);
    step; check("fetch_req", imem_req, 1); check("fetch_pc0", current_address, 16'h0000);
    step; check("seq_4", current_address, 16'h0004);
    step; check("seq_8", current_address, 16'h0008);
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step; check("stall_pc", current_address, 16'h0008); check("stall_req", imem_req, 1);
    end
    imem_ack = 1'b1;
    step; check("seq_c", current_address, 16'h000C);
    step; check("seq_10", current_address, 16'h0010);
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
    step; branch_taken = 1'b0; jump = 1'b1; jump_target = 16'h0080;
    step; jump = 1'b0;
    check("buf_hold", current_address, 16'h0010);
    imem_ack = 1'b1;
    step; check("buf_last_wins", current_address, 16'h0080);
    step; check("buf_cleared", current_address, 16'h0084);
    jump = 1'b1; jump_target = 16'h0100; branch_taken = 1'b1; branch_target = 16'h0200;
    step; check("jump_prio", current_address, 16'h0100);
    branch_taken = 1'b0; jump_target = 16'hFFFC;
    step; check("jump_fffc", current_address, 16'hFFFC);
    jump = 1'b0;
    step; check("wrap", current_address, 16'h0000);
    jump = 1'b1; jump_target = 16'h0042;
    step; check("misalign_pc", current_address, 16'h0042); check("misalign_err", misalign_err, exp_err);
    jump_target = 16'h0020;
    step; jump = 1'b0;
    check("aligned_pc", current_address, 16'h0020); check("err_sticky", misalign_err, exp_err);
    imem_ack = 1'b0; halt = 1'b1;
    step; halt = 1'b0;
    check("halt_wait_pc", current_address, 16'h0020); check("halt_wait", halted, 0);
    imem_ack = 1'b1;
    step; check("halt_pc", current_address, 16'h0024); check("halted", halted, 1); check("halt_req", imem_req, 0);
    jump = 1'b1; jump_target = 16'h0300;
    step; jump = 1'b0;
    check("halt_frozen", current_address, 16'h0024); check("halt_stays", halted, 1);
    #3 reset = 1'b1;
    #1 check("arst_pc", current_address, 16'h0000); check("arst_halted", halted, 0);
    check("arst_err", misalign_err, 0); check("arst_req", imem_req, 0);
    @(negedge clk) reset = 1'b0;
    step; check("reboot_req", imem_req, 1);
    step; check("reboot_seq", current_address, 16'h0004);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and fetch sequencer at the producer end of the pc_adder interface.
- Drives current_address into pc_adder and instruction memory; consumes next_address (current_address + 4) back from pc_adder.
- Chooses the next PC from sequential, branch or jump sources.
- Holds the fetch address stable under a req/ack handshake with instruction memory and buffers redirects that arrive mid-fetch.

Parameters:
- ADDR_WIDTH, 16, PC width; must match pc_adder.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- current_address  output  ADDR_WIDTH  registered PC; to pc_adder and imem address.
- next_address  input  ADDR_WIDTH  sequential PC from pc_adder (current_address + 4).
- branch_taken  input  1  one-cycle pulse; redirect to branch_target.
- branch_target  input  ADDR_WIDTH  branch destination.
- jump  input  1  one-cycle pulse; redirect to jump_target.
- jump_target  input  ADDR_WIDTH  jump destination.
- halt  input  1  one-cycle pulse; stop fetching after the current fetch completes.
- imem_req  output  1  fetch request; current_address valid while high.
- imem_ack  input  1  imem accepted or returned the fetch at current_address.
- halted  output  1  high in HALTED state.
- misalign_err  output  1  sticky alignment error (see Optional Feature).

Behaviour:
- Reset, asynchronous and any time, including mid-fetch:
  - current_address = RESET_VECTOR; imem_req = 0; halted = 0; misalign_err = 0.
  - Pending redirect and halt flags cleared; state = BOOT.
- States:
  - BOOT: imem_req = 0 for exactly one cycle after reset deasserts, then go to FETCH.
  - FETCH: imem_req = 1.
    - current_address must not change while imem_req = 1 and imem_ack = 0.
    - On a cycle with imem_ack = 1, current_address takes the selected next PC at that clock edge.
    - imem_req stays high, so back-to-back fetches give one fetch per cycle when imem_ack is held high.
  - HALTED: imem_req = 0; halted = 1; current_address frozen. Exit only by reset.
- Next-PC selection at an ack edge, highest priority first:
  - jump in the same cycle → jump_target.
  - branch_taken in the same cycle → branch_target.
  - pending redirect → its stored target.
  - otherwise → next_address.
- Redirect buffering:
  - jump or branch_taken in FETCH without imem_ack is stored as a pending target. If both are high, jump wins.
  - A later redirect before the ack overwrites the pending target (last wins).
  - The pending target is cleared on the ack edge that consumes it.
- Redirects in BOOT or HALTED are ignored.
- halt:
  - Sets a halt-pending flag.
  - At the next ack edge, the PC updates normally, then the state goes to HALTED.
  - halt with imem_ack in the same cycle halts at that edge.
- Arithmetic: the PC is a plain ADDR_WIDTH register with no internal adder. A wrap in next_address (16'hFFFC → 16'h0000) is accepted unchanged.
- Latency: a redirect asserted with ack appears on current_address the next cycle. A buffered redirect appears the cycle after its ack.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Any redirect target loaded into the PC with bits [1:0] != 2'b00 sets misalign_err, which stays set until reset.
  - The PC still loads the target unchanged.
- When undefined: misalign_err is tied to 0 and no check logic is built.

Test Plan:
- Reset → current_address = 16'h0000 and imem_req = 0 for 1 cycle → then imem_req = 1; with ack held high, PC steps 0000 → 0004 → 0008 → 000C on consecutive cycles.
- Ack held low 3 cycles at PC = 0008 → current_address stays 0008 and imem_req stays 1 → ack high → 000C.
- At PC = 0010, branch_taken with target 0040 while ack low, then jump with target 0080 one cycle later while ack low, then ack → PC = 0080; next ack → 0084.
- jump (target 0100) and branch_taken (target 0200) together with ack → PC = 0100.
- PC forced to FFFC via jump, then ack → PC = 0000 (wrap accepted).
- halt pulse at PC = 0020 with ack low, then ack → PC = 0024, halted = 1, imem_req = 0; later redirects ignored; asynchronous reset mid-HALTED → PC = 0000, halted = 0.
- With PC_ALIGN_CHECK_EN: jump to 0042 → PC = 0042 and misalign_err = 1, staying 1 until reset.
- Without PC_ALIGN_CHECK_EN: the same jump leaves misalign_err = 0.
